georam_bus: RTL and testbench

C64-side expansion-port front end for the GeoRAM-compatible cartridge; directly upstream of the SDRAM controller. Decodes /IO1 and /IO2, holds the page, block and control registers, and forms the controller's request (RAMSEL, nWE, A[21:0], WRD). It also steers the C64 data bus for reads of the RAM window and of register readback.

---
 rtl/georam_bus.sv | 100 ++++++++++
 tb/tb_georam_bus.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/georam_bus.sv
// GeoRAM expansion-port front end: /IO1 window and /IO2 register decode,
// SDRAM request forming, C64 read steering and page auto-increment.
module georam_bus #(
   parameter logic [7:0] BLOCK_MASK = 8'hFF
) (
   input  logic        PHI2,
   input  logic        nRESET,
   input  logic        nIO1,
   input  logic        nIO2,
   input  logic        RnW,
   input  logic [7:0]  CA,
   input  logic [7:0]  CD,
   input  logic [7:0]  RDD,
   output logic        RAMSEL,
   output logic        nWE,
   output logic [21:0] A,
   output logic [7:0]  WRD,
   output logic        DOE,
   output logic [7:0]  DOUT
);

   typedef enum logic {IDLE, ARMED} ainc_t;

   ainc_t       state, state_nxt;
   logic [5:0]  page, page_nxt;
   logic [7:0]  block, block_nxt;
   logic [2:0]  ctrl, ctrl_nxt;
   logic [13:0] bp_inc;
   logic        wr_ctrl, wr_page, wr_block, deff_hit;
   logic        rd_en;
   logic [7:0]  rd_data;

   assign wr_ctrl  = !nIO2 && !RnW && (CA == 8'hFD);
   assign wr_page  = !nIO2 && !RnW && (CA == 8'hFE);
   assign wr_block = !nIO2 && !RnW && (CA == 8'hFF);
   // Any $DEFF access arms, including a write suppressed by WP.
   assign deff_hit = !nIO1 && (CA == 8'hFF) && ctrl[0];
   assign bp_inc   = {block, page} + 14'd1;

   always_ff @(negedge PHI2) begin
      if (!nRESET) begin
         state <= IDLE;
         page  <= '0;
         block <= '0;
         ctrl  <= '0;
      end else begin
         state <= state_nxt;
         page  <= page_nxt;
         block <= block_nxt;
         ctrl  <= ctrl_nxt;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      page_nxt  = page;
      block_nxt = block;
      ctrl_nxt  = ctrl;
      case (state)
         IDLE:  state_nxt = deff_hit ? ARMED : IDLE;
         ARMED: begin
            state_nxt = deff_hit ? ARMED : IDLE;
            // A C64 write to PAGE or BLOCK on this edge supersedes the increment.
            if (!wr_page && !wr_block) begin
               page_nxt  = bp_inc[5:0];
               block_nxt = bp_inc[13:6] & BLOCK_MASK;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (wr_page)  page_nxt  = CD[5:0];
      if (wr_block) block_nxt = CD & BLOCK_MASK;
      if (wr_ctrl)  ctrl_nxt  = CD[2:0];
   end

   assign A      = nRESET ? {block, page, CA} : {14'd0, CA};
   assign RAMSEL = !nIO1 && nRESET;
   assign nWE    = !(!RnW && !ctrl[1] && nRESET);
   assign WRD    = CD;

   always_comb begin
      rd_en   = 1'b0;
      rd_data = 8'h00;
      if (!nIO1) begin
         rd_en   = 1'b1;
         rd_data = RDD;
      end else if (!nIO2) begin
         case (CA)
            8'hFD: begin rd_en = 1'b1;    rd_data = {5'b0, ctrl}; end
            8'hFE: begin rd_en = ctrl[2]; rd_data = {2'b0, page}; end
            8'hFF: begin rd_en = ctrl[2]; rd_data = block;        end
            default: ;
         endcase
      end
   end

   assign DOE  = PHI2 && RnW && nRESET && rd_en;
   assign DOUT = (RnW && nRESET && rd_en) ? rd_data : 8'h00;

endmodule

// File: tb/tb_georam_bus.sv
// Directed bench for georam_bus: stimulus pushes expected bus outputs into a
// queue; a monitor pops and compares them late in each PHI2-high phase.
module tb_georam_bus;

   typedef struct {
      string       name;
      bit          id;
      logic [21:0] a;
      logic        ramsel;
      logic        nwe;
      logic        doe;
      logic [7:0]  dout;
   } exp_t;

   logic        PHI2 = 1'b0;
   logic        nRESET = 1'b0;
   logic        nIO1 = 1'b1, nIO2 = 1'b1, RnW = 1'b1;
   logic [7:0]  CA = 8'h00, CD = 8'h00, RDD;
   logic        ramsel0, nwe0, doe0, ramsel1, nwe1, doe1;
   logic [21:0] a0, a1;
   logic [7:0]  wrd0, wrd1, dout0, dout1;
   logic [7:0]  mem [0:255];

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   always #50 PHI2 = ~PHI2;

   georam_bus u_dut0 (
      .PHI2(PHI2), .nRESET(nRESET), .nIO1(nIO1), .nIO2(nIO2), .RnW(RnW),
      .CA(CA), .CD(CD), .RDD(RDD), .RAMSEL(ramsel0), .nWE(nwe0), .A(a0),
      .WRD(wrd0), .DOE(doe0), .DOUT(dout0));

   georam_bus #(.BLOCK_MASK(8'h0F)) u_dut1 (
      .PHI2(PHI2), .nRESET(nRESET), .nIO1(nIO1), .nIO2(nIO2), .RnW(RnW),
      .CA(CA), .CD(CD), .RDD(RDD), .RAMSEL(ramsel1), .nWE(nwe1), .A(a1),
      .WRD(wrd1), .DOE(doe1), .DOUT(dout1));

   // Stand-in for the SDRAM: low address byte only is enough here.
   assign RDD = mem[a0[7:0]];
   always @(negedge PHI2)
      if (ramsel0 && !nwe0) mem[a0[7:0]] <= wrd0;

   task automatic cyc(input logic rst, input logic io1, input logic io2,
                      input logic rnw, input logic [7:0] ca, input logic [7:0] cd);
      @(negedge PHI2);
      #1;
      nRESET = rst; nIO1 = io1; nIO2 = io2; RnW = rnw; CA = ca; CD = cd;
   endtask

   task automatic expect_out(input string name, input bit id, input logic [21:0] a,
                             input logic ramsel, input logic nwe, input logic doe,
                             input logic [7:0] dout);
      exp_t e;
      e.name = name; e.id = id; e.a = a; e.ramsel = ramsel;
      e.nwe = nwe; e.doe = doe; e.dout = dout;
      q.push_back(e);
   endtask

   initial begin
      exp_t        e;
      logic [21:0] ga;
      logic        gr, gw, gd;
      logic [7:0]  go;
      forever begin
         @(posedge PHI2);
         #40;
         while (q.size() > 0) begin
            e  = q.pop_front();
            ga = e.id ? a1 : a0;
            gr = e.id ? ramsel1 : ramsel0;
            gw = e.id ? nwe1 : nwe0;
            gd = e.id ? doe1 : doe0;
            go = e.id ? dout1 : dout0;
            tests++;
            if ({ga, gr, gw, gd, go} !== {e.a, e.ramsel, e.nwe, e.doe, e.dout}) begin
               fails++;
               $display("FAIL %s: got A=%h RAMSEL=%b nWE=%b DOE=%b DOUT=%h, want A=%h RAMSEL=%b nWE=%b DOE=%b DOUT=%h",
                        e.name, ga, gr, gw, gd, go, e.a, e.ramsel, e.nwe, e.doe, e.dout);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

      // reset state, including a window access while held in reset
      cyc(0, 1, 1, 1, 8'h00, 8'h00); expect_out("reset_idle", 0, 22'h000000, 0, 1, 0, 8'h00);
      cyc(0, 0, 1, 1, 8'h34, 8'h00); expect_out("reset_win",  0, 22'h000034, 0, 1, 0, 8'h00);

      // BLOCK=12, PAGE=FF&3F, RBEN; window and register readback
      cyc(1, 1, 0, 0, 8'hFF, 8'h12); expect_out("wr_block", 0, 22'h0000FF, 0, 0, 0, 8'h00);
      cyc(1, 1, 0, 0, 8'hFE, 8'hFF);
      cyc(1, 1, 0, 0, 8'hFD, 8'h04);
      cyc(1, 0, 1, 1, 8'h34, 8'h00); expect_out("win_read",  0, 22'h04BF34, 1, 1, 1, 8'h6E);
      cyc(1, 1, 0, 1, 8'hFE, 8'h00); expect_out("page_rb",   0, 22'h04BFFE, 0, 1, 1, 8'h3F);
      cyc(1, 1, 0, 1, 8'hFD, 8'h00); expect_out("ctrl_rb",   0, 22'h04BFFD, 0, 1, 1, 8'h04);

      // BLOCK_MASK applied on write
      cyc(1, 1, 0, 0, 8'hFF, 8'hA5);
      cyc(1, 1, 0, 1, 8'hFF, 8'h00);
      expect_out("mask0F_block_rb", 1, 22'h017FFF, 0, 1, 1, 8'h05);
      expect_out("maskFF_block_rb", 0, 22'h297FFF, 0, 1, 1, 8'hA5);

      // auto-increment wrap from BLOCK=FF, PAGE=63
      cyc(1, 1, 0, 0, 8'hFF, 8'hFF);
      cyc(1, 1, 0, 0, 8'hFE, 8'h3F);
      cyc(1, 1, 0, 0, 8'hFD, 8'h01);
      cyc(1, 0, 1, 1, 8'hFF, 8'h00); expect_out("deff_read",  0, 22'h3FFFFF, 1, 1, 1, 8'hA5);
      cyc(1, 1, 1, 1, 8'h00, 8'h00); expect_out("inc_delay",  0, 22'h3FFF00, 0, 1, 0, 8'h00);
      cyc(1, 1, 1, 1, 8'h00, 8'h00); expect_out("inc_wrap",   0, 22'h000000, 0, 1, 0, 8'h00);

      // PAGE write on the increment edge wins
      cyc(1, 0, 1, 1, 8'hFF, 8'h00); expect_out("deff_read2", 0, 22'h0000FF, 1, 1, 1, 8'hA5);
      cyc(1, 1, 0, 0, 8'hFE, 8'h10); expect_out("wr_page",    0, 22'h0000FE, 0, 0, 0, 8'h00);
      cyc(1, 1, 1, 1, 8'h00, 8'h00); expect_out("page_wins",  0, 22'h001000, 0, 1, 0, 8'h00);
      cyc(1, 1, 1, 1, 8'h00, 8'h00); expect_out("no_late_inc",0, 22'h001000, 0, 1, 0, 8'h00);

      // write protect turns a window write into a read
      cyc(1, 0, 1, 0, 8'h00, 8'hAA); expect_out("win_write",  0, 22'h001000, 1, 0, 0, 8'h00);
      cyc(1, 1, 0, 0, 8'hFD, 8'h02);
      cyc(1, 0, 1, 0, 8'h00, 8'h55); expect_out("wp_write",   0, 22'h001000, 1, 1, 0, 8'h00);
      cyc(1, 0, 1, 1, 8'h00, 8'h00); expect_out("wp_old_byte",0, 22'h001000, 1, 1, 1, 8'hAA);

      // reset beats a concurrent BLOCK write
      cyc(1, 1, 0, 0, 8'hFD, 8'h04);
      cyc(0, 1, 0, 0, 8'hFF, 8'h77); expect_out("rst_wr",     0, 22'h0000FF, 0, 1, 0, 8'h00);
      cyc(1, 1, 0, 1, 8'hFD, 8'h00); expect_out("rst_ctrl_rb",0, 22'h0000FD, 0, 1, 1, 8'h00);
      cyc(1, 1, 0, 1, 8'hFF, 8'h00); expect_out("rst_block",  0, 22'h0000FF, 0, 1, 0, 8'h00);

      cyc(1, 1, 1, 1, 8'h00, 8'h00);
      @(negedge PHI2);
      @(negedge PHI2);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expected entries unchecked, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
